// File: rtl/mul9_pkg.sv
// Shared constants, column geometry and FSM state type for the 9x9
// partial-product serializer.
package mul9_pkg;

  localparam int N     = 9;
  localparam int NCOL  = 2 * N - 1;
  localparam int PRODW = 2 * N;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    CAPTURE
  } state_e;

  // Number of partial-product bits that land in column c.
  function automatic int col_height(input int c, input int n);
    int lo;
    lo = (c < (2 * n - 2) - c) ? c : (2 * n - 2) - c;
    return lo + 1;
  endfunction

  // Lowest multiplicand index contributing to column c.
  function automatic int col_start(input int c, input int n);
    return (c > n - 1) ? c - (n - 1) : 0;
  endfunction

endpackage

// File: rtl/pp_serializer_if.sv
// Operand handshake and result bus between the bench driver and pp_serializer.
interface pp_serializer_if #(
  parameter int N    = 9,
  parameter int ERRW = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [N-1:0]      in_a;
  logic [N-1:0]      in_b;
  logic              out_valid;
  logic [2*N-1:0]    out_product;
  logic [2*N-1:0]    out_expected;
  logic              out_error;
  logic [ERRW-1:0]   err_count;

  modport master (
    output in_valid, in_a, in_b,
    input  in_ready, out_valid, out_product, out_expected, out_error, err_count
  );

  modport slave (
    input  in_valid, in_a, in_b,
    output in_ready, out_valid, out_product, out_expected, out_error, err_count
  );
endinterface

// File: rtl/pp_bit_select.sv
// Combinational column selector: for shift step k, picks the partial-product
// bit each column feeds into its shift register (0 while the column is padding).
module pp_bit_select
  import mul9_pkg::col_height, mul9_pkg::col_start;
#(
  parameter int N  = mul9_pkg::N,
  parameter int KW = $clog2(N)
) (
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  input  logic [KW-1:0]    k,
  output logic [2*N-2:0]   src
);

  localparam int IW = $clog2(N);

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    int off;
    int i;
    src = '0;
    off = 0;
    i   = 0;
    for (int c = 0; c < 2 * N - 1; c++) begin
      // Short columns idle for the first N-h steps so all columns end together.
      off = N - col_height(c, N);
      if (int'(k) >= off && int'(k) < N) begin
        i      = col_start(c, N) + int'(k) - off;
        src[c] = a[IW'(i)] & b[IW'(c - i)];
      end
    end
  end

endmodule

// File: rtl/pp_serializer.sv
// Operand front end and result checker: streams the 81 partial-product bits
// into the column shift registers, then captures and checks the compressor sum.
module pp_serializer
  import mul9_pkg::state_e, mul9_pkg::IDLE, mul9_pkg::SHIFT, mul9_pkg::CAPTURE;
#(
  parameter int N    = mul9_pkg::N,
  parameter int ERRW = 16
) (
  input  logic clk,
  input  logic rst,
  pp_serializer_if.slave bus,
  output logic src0_,  output logic src1_,  output logic src2_,  output logic src3_,
  output logic src4_,  output logic src5_,  output logic src6_,  output logic src7_,
  output logic src8_,  output logic src9_,  output logic src10_, output logic src11_,
  output logic src12_, output logic src13_, output logic src14_, output logic src15_,
  output logic src16_,
  input  logic dst0,  input  logic dst1,  input  logic dst2,  input  logic dst3,
  input  logic dst4,  input  logic dst5,  input  logic dst6,  input  logic dst7,
  input  logic dst8,  input  logic dst9,  input  logic dst10, input  logic dst11,
  input  logic dst12, input  logic dst13, input  logic dst14, input  logic dst15,
  input  logic dst16, input  logic dst17
);

  localparam int NC = 2 * N - 1;
  localparam int PW = 2 * N;
  localparam int KW = $clog2(N);

  state_e          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic [N-1:0]    a_q, a_d, b_q, b_d;
  logic [PW-1:0]   prod_exp_q, prod_exp_d;
  logic [PW-1:0]   out_product_q, out_product_d;
  logic [PW-1:0]   out_expected_q, out_expected_d;
  logic            out_valid_q, out_valid_d;
  logic            out_error_q, out_error_d;
  logic [ERRW-1:0] err_count_q, err_count_d;

  logic [NC-1:0]   sel_src;
  logic [NC-1:0]   src_vec;
  logic [PW-1:0]   dst;
  logic            accept;
  logic            mismatch;

  pp_bit_select #(.N(N), .KW(KW)) u_bit_select (
    .a   (a_q),
    .b   (b_q),
    .k   (k_q),
    .src (sel_src)
  );

  assign dst = {dst17, dst16, dst15, dst14, dst13, dst12, dst11, dst10, dst9,
                dst8,  dst7,  dst6,  dst5,  dst4,  dst3,  dst2,  dst1,  dst0};

  assign bus.in_ready = (state_q == IDLE);
  assign accept       = bus.in_valid && bus.in_ready;
  assign mismatch     = (dst != prod_exp_q);

  // Columns only carry data while shifting; the register keeps clocking zeros otherwise.
  assign src_vec = (state_q == SHIFT) ? sel_src : '0;

  always_comb begin
    state_d        = state_q;
    k_d            = k_q;
    a_d            = a_q;
    b_d            = b_q;
    prod_exp_d     = prod_exp_q;
    out_product_d  = out_product_q;
    out_expected_d = out_expected_q;
    out_error_d    = out_error_q;
    err_count_d    = err_count_q;
    out_valid_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          a_d        = bus.in_a;
          b_d        = bus.in_b;
          prod_exp_d = PW'(bus.in_a) * PW'(bus.in_b);
          k_d        = '0;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        k_d = k_q + 1'b1;
        if (k_q == KW'(N - 1)) begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        out_product_d  = dst;
        out_expected_d = prod_exp_q;
        out_error_d    = mismatch;
        out_valid_d    = 1'b1;
        if (mismatch && err_count_q != '1) begin
          err_count_d = err_count_q + 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      k_q            <= '0;
      a_q            <= '0;
      b_q            <= '0;
      prod_exp_q     <= '0;
      out_product_q  <= '0;
      out_expected_q <= '0;
      out_valid_q    <= 1'b0;
      out_error_q    <= 1'b0;
      err_count_q    <= '0;
    end else begin
      state_q        <= state_d;
      k_q            <= k_d;
      a_q            <= a_d;
      b_q            <= b_d;
      prod_exp_q     <= prod_exp_d;
      out_product_q  <= out_product_d;
      out_expected_q <= out_expected_d;
      out_valid_q    <= out_valid_d;
      out_error_q    <= out_error_d;
      err_count_q    <= err_count_d;
    end
  end

  assign bus.out_valid    = out_valid_q;
  assign bus.out_product  = out_product_q;
  assign bus.out_expected = out_expected_q;
  assign bus.out_error    = out_error_q;
  assign bus.err_count    = err_count_q;

  assign src0_  = src_vec[0];
  assign src1_  = src_vec[1];
  assign src2_  = src_vec[2];
  assign src3_  = src_vec[3];
  assign src4_  = src_vec[4];
  assign src5_  = src_vec[5];
  assign src6_  = src_vec[6];
  assign src7_  = src_vec[7];
  assign src8_  = src_vec[8];
  assign src9_  = src_vec[9];
  assign src10_ = src_vec[10];
  assign src11_ = src_vec[11];
  assign src12_ = src_vec[12];
  assign src13_ = src_vec[13];
  assign src14_ = src_vec[14];
  assign src15_ = src_vec[15];
  assign src16_ = src_vec[16];

endmodule

// File: tb/tb_pp_serializer.sv
// Directed bench for pp_serializer with a behavioural column shift register
// and popcount compressor standing in for the downstream cascade.
module tb_pp_serializer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pp_serializer_if #(.N(9), .ERRW(16)) bus ();

  wire  [16:0]      src;
  logic [17:0]      dst;
  logic [17:0]      dst_m;
  logic             force_msb = 1'b0;
  logic [16:0][8:0] sr;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int acc_cyc  = 0;
  logic [16:0] src_hist [9];

  pp_serializer #(.N(9), .ERRW(16)) dut (
    .clk (clk), .rst (rst), .bus (bus),
    .src0_ (src[0]),   .src1_ (src[1]),   .src2_ (src[2]),   .src3_ (src[3]),
    .src4_ (src[4]),   .src5_ (src[5]),   .src6_ (src[6]),   .src7_ (src[7]),
    .src8_ (src[8]),   .src9_ (src[9]),   .src10_ (src[10]), .src11_ (src[11]),
    .src12_ (src[12]), .src13_ (src[13]), .src14_ (src[14]), .src15_ (src[15]),
    .src16_ (src[16]),
    .dst0 (dst[0]),   .dst1 (dst[1]),   .dst2 (dst[2]),   .dst3 (dst[3]),
    .dst4 (dst[4]),   .dst5 (dst[5]),   .dst6 (dst[6]),   .dst7 (dst[7]),
    .dst8 (dst[8]),   .dst9 (dst[9]),   .dst10 (dst[10]), .dst11 (dst[11]),
    .dst12 (dst[12]), .dst13 (dst[13]), .dst14 (dst[14]), .dst15 (dst[15]),
    .dst16 (dst[16]), .dst17 (dst[17])
  );

  function automatic int hgt(input int c);
    return ((c < 16 - c) ? c : 16 - c) + 1;
  endfunction

  // Per-column shift register (no enable, no reset) and cycle counter.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int c = 0; c < 17; c++) begin
      sr[5'(c)] <= {sr[5'(c)][7:0], src[5'(c)]};
    end
  end

  // Compressor: each column contributes the popcount of its newest h(c) bits.
  always_comb begin
    dst_m = '0;
    for (int c = 0; c < 17; c++) begin
      for (int j = 0; j < 9; j++) begin
        if (j < hgt(c)) dst_m = dst_m + (18'(sr[5'(c)][4'(j)]) << c);
      end
    end
    dst = force_msb ? (dst_m | 18'h20000) : dst_m;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!bus.in_ready && n < 30) begin
      step();
      n++;
    end
    check("ready_wait", 32'(bus.in_ready), 32'd1);
  endtask

  // Accept one pair, record src for k=0..8, and stop in the out_valid cycle.
  task automatic run_op(input logic [8:0] a, input logic [8:0] b);
    int   n;
    logic busy;
    wait_ready();
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_valid = 1'b1;
    step();
    acc_cyc      = cyc;
    bus.in_valid = 1'b0;
    busy         = 1'b0;
    for (int k = 0; k < 9; k++) begin
      src_hist[k] = src;
      busy = busy | bus.in_ready | bus.out_valid;
      step();
    end
    check("capture_src", 32'(src), 32'd0);
    check("busy_ready", 32'(busy | bus.in_ready | bus.out_valid), 32'd0);
    n = 0;
    while (!bus.out_valid && n < 12) begin
      step();
      n++;
    end
    check("out_valid", 32'(bus.out_valid), 32'd1);
    check("latency", 32'(cyc - acc_cyc), 32'd10);
    check("valid_cycle_ready", 32'(bus.in_ready), 32'd1);
  endtask

  task automatic check_result(input string tag, input logic [17:0] prod, input logic [17:0] expd,
                              input logic err, input logic [15:0] cnt);
    check({tag, "_product"},  32'(bus.out_product),  32'(prod));
    check({tag, "_expected"}, 32'(bus.out_expected), 32'(expd));
    check({tag, "_error"},    32'(bus.out_error),    32'(err));
    check({tag, "_count"},    32'(bus.err_count),    32'(cnt));
  endtask

  initial begin
    logic [16:0] mask;
    logic [8:0]  pa, pb, ra, rb;
    int          prev, t, n, vcount;

    bus.in_valid = 1'b0;
    bus.in_a     = '0;
    bus.in_b     = '0;

    // Reset state.
    #22;
    check("rst_ready",    32'(bus.in_ready),     32'd1);
    check("rst_valid",    32'(bus.out_valid),    32'd0);
    check("rst_error",    32'(bus.out_error),    32'd0);
    check("rst_product",  32'(bus.out_product),  32'd0);
    check("rst_expected", 32'(bus.out_expected), 32'd0);
    check("rst_count",    32'(bus.err_count),    32'd0);
    check("rst_src",      32'(src),              32'd0);
    @(negedge clk);
    rst = 1'b0;
    step();

    // 1 x 1: only column 0 fires, at the last shift step.
    run_op(9'd1, 9'd1);
    for (int k = 0; k < 9; k++) check("t1_src", 32'(src_hist[k]), (k == 8) ? 32'h1 : 32'h0);
    check_result("t1", 18'h00001, 18'h00001, 1'b0, 16'd0);
    step();
    check("t1_pulse", 32'(bus.out_valid), 32'd0);
    check("t1_hold", 32'(bus.out_product), 32'h1);

    // 0x100 squared: only column 16 fires.
    run_op(9'h100, 9'h100);
    for (int k = 0; k < 9; k++) check("t2_src", 32'(src_hist[k]), (k == 8) ? 32'h10000 : 32'h0);
    check_result("t2", 18'h10000, 18'h10000, 1'b0, 16'd0);

    // All ones: at step k columns 8-k..8+k are active.
    run_op(9'h1FF, 9'h1FF);
    for (int k = 0; k < 9; k++) begin
      mask = '0;
      for (int c = 8 - k; c <= 8 + k; c++) mask[5'(c)] = 1'b1;
      check("t3_src", 32'(src_hist[k]), 32'(mask));
    end
    check_result("t3", 18'h3FC01, 18'h3FC01, 1'b0, 16'd0);

    // Corrupted compressor MSB: mismatch reported and counted.
    force_msb = 1'b1;
    run_op(9'd3, 9'd5);
    force_msb = 1'b0;
    check_result("t4", 18'h2000F, 18'h0000F, 1'b1, 16'd1);

    // Zero operand: no column ever fires; count holds.
    run_op(9'd0, 9'h1AB);
    mask = '0;
    for (int k = 0; k < 9; k++) mask = mask | src_hist[k];
    check("t5_src", 32'(mask), 32'd0);
    check_result("t5", 18'h0, 18'h0, 1'b0, 16'd1);

    // Reset at k=4 with the register full of ones.
    wait_ready();
    bus.in_a     = 9'h1FF;
    bus.in_b     = 9'h1FF;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    for (int k = 0; k < 4; k++) step();
    rst = 1'b1;
    #1;
    check("mid_rst_ready", 32'(bus.in_ready),  32'd1);
    check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_src",   32'(src),           32'd0);
    check("mid_rst_count", 32'(bus.err_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    vcount = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus.out_valid) vcount++;
    end
    check("mid_rst_no_valid", 32'(vcount), 32'd0);
    run_op(9'd7, 9'd9);
    check_result("t6", 18'h0003F, 18'h0003F, 1'b0, 16'd0);

    // in_valid held high: back-to-back accepts every 11 cycles.
    bus.in_valid = 1'b1;
    prev = 0;
    for (int op = 0; op < 4; op++) begin
      pa = 9'($urandom_range(0, 511));
      pb = 9'($urandom_range(0, 511));
      bus.in_a = pa;
      bus.in_b = pb;
      wait_ready();
      step();
      t = cyc;
      if (op > 0) check("held_spacing", 32'(t - prev), 32'd11);
      prev = t;
      // Operands offered while busy must be ignored.
      bus.in_a = ~pa;
      bus.in_b = ~pb;
      n = 0;
      while (!bus.out_valid && n < 14) begin
        step();
        n++;
      end
      check("held_latency", 32'(cyc - t), 32'd10);
      check("held_product", 32'(bus.out_product), 32'({9'd0, pa} * {9'd0, pb}));
      check("held_error", 32'(bus.out_error), 32'd0);
    end
    bus.in_valid = 1'b0;

    // Random soak.
    for (int i = 0; i < 500; i++) begin
      ra = 9'($urandom_range(0, 511));
      rb = 9'($urandom_range(0, 511));
      run_op(ra, rb);
      check("rand_product",  32'(bus.out_product),  32'({9'd0, ra} * {9'd0, rb}));
      check("rand_expected", 32'(bus.out_expected), 32'({9'd0, ra} * {9'd0, rb}));
    end
    check("rand_count", 32'(bus.err_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pp_serializer.md
# pp_serializer

Operand front end and result checker for the 9x9 multiplier cascade bench. It accepts a 9-bit operand pair through a valid/ready handshake and forms the 81 partial-product bits. It streams them column by column into the per-column shift register over nine cycles. One cycle later it captures the compressor's 18 result bits and compares them with a locally computed golden product, keeping a saturating error count.

## Interface
Parameters:
- N, 9, operand width; the column count (2N-1 = 17) and product width (2N = 18) are derived from it.
- ERRW, 16, width of the error counter.

Ports (one clock; reset is asynchronous and active-high):
- clk  input  1  clock; also drives the downstream shift register.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  1  operand pair offered.
- in_ready  output  1  block can accept; high only in IDLE.
- in_a  input  9  multiplicand.
- in_b  input  9  multiplier.
- src0_ .. src16_  output  1 each  serial column bits to the shift register, one per column.
- dst0 .. dst17  input  1 each  compressor result bits; dst0 is the LSB.
- out_valid  output  1  one-cycle pulse; result fields are valid.
- out_product  output  18  captured {dst17..dst0}.
- out_expected  output  18  golden a*b.
- out_error  output  1  out_product != out_expected; qualified by out_valid.
- err_count  output  ERRW  saturating count of mismatches since reset.

## Operation
- FSM states are IDLE, SHIFT and CAPTURE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, the block latches a, b and prod_exp = a*b (18-bit, unsigned).
  - It clears k and moves to SHIFT.
- SHIFT, with counter k from 0 to 8:
  - Column c has height h(c) = min(c, 16-c) + 1.
  - For k < 9-h(c), src{c}_ = 0. These bits are flushed out of the register before use.
  - Otherwise, let m = k-(9-h(c)) and i = max(0, c-8) + m. Then src{c}_ = a[i] & b[c-i].
  - When k = 8, the block moves to CAPTURE.
- CAPTURE:
  - The shift register now holds exactly the partial-product bits of every column, and the combinational compressor presents dst.
  - At the edge ending this cycle, the block registers out_product = dst, out_expected = prod_exp and out_error = (dst != prod_exp).
  - If there is a mismatch, err_count increments, saturating at all-ones.
  - The block then moves to IDLE.
- src*_ are 0 in IDLE and CAPTURE. The shift register shifts every cycle and has no enable; zeros shifted in after capture are harmless.
- out_valid is asserted for the single cycle after the CAPTURE edge. In that same cycle the block is in IDLE with in_ready=1.
- The result registers hold their values until the next capture.
- src*_ are combinational from state, k and the latched operands, so they are glitch-free at the clock edge.

## Timing
- The handshake edge is E0. SHIFT bits are sampled by the shift register at edges E1..E9, and capture occurs at E10.
- out_valid is high during the cycle after E10, so latency from the accept edge to out_valid is 10 edges.
- Throughput is one operation per 11 cycles, because there is no overlap; in_valid held high is accepted again in the out_valid cycle.
- in_valid while busy is ignored; the operands are not latched.
- Reset values:
  - State is IDLE, so in_ready=1.
  - All src*_ are 0, out_valid=0 and out_error=0.
  - out_product, out_expected and err_count are 0.
- Reset mid-operation:
  - The in-flight operation is abandoned with no out_valid and no count change.
  - The shift register is not reset, so its contents are stale. The next operation's nine SHIFT cycles fully overwrite every column, so no flush is required.
- Boundary conditions:
  - a = 0 or b = 0: all src*_ stay 0 and the expected product is 0.
  - a = b = 0x1FF: all 81 bits are 1 and the expected product is 0x3FC01.
  - err_count at saturation stays all-ones.

## Structure
- Shared package mul9_pkg holds:
  - N, NCOL = 2N-1, PRODW = 2N;
  - the column-height function h(c) and start offset max(0, c-8);
  - the state enum {IDLE, SHIFT, CAPTURE}.
- One sub-module, pp_bit_select, is combinational. It takes a, b and k, and outputs the 17-bit src vector using the column/index rule above. It is instantiated once.
- The top level holds the FSM, counter, operand and golden registers, capture and compare logic, and the error counter.

## Test plan
- a=1, b=1: src0_ high only at k=8, all other src*_ always 0; out_product=0x00001, out_error=0.
- a=0x100, b=0x100: src16_ high only at k=8; out_product=0x10000. Then a=0x1FF, b=0x1FF: out_product=0x3FC01, out_error=0, err_count=0.
- a=3, b=5 with the bench forcing dst17 to 1 during CAPTURE: out_expected=0x0000F, out_error=1, err_count=1.
- rst asserted during SHIFT at k=4: in_ready=1 and out_valid=0 immediately. Next, a=7, b=9 gives out_product=0x0003F with no error, despite stale register contents.
- in_valid held high with four random pairs: accepts occur 11 cycles apart, each out_valid comes 10 edges after its accept, and all products match.
- 500 random pairs compared against a*b in the model: err_count=0, and in_ready is never high outside IDLE.
